// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse width meter.
package pulse_meter_pkg;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam int CNT_W_DEF = 16;

  // Largest value a w-bit counter can report (all ones).
  function automatic logic [31:0] cnt_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_meter.sv
// Purpose: measures high time of a serial input from rising/falling edge pulses, saturating count.
// Latency: result valid the cycle after the falling pulse; one-entry output slot.
// Backpressure: a full, unconsumed slot drops the new measurement and pulses drop_o.
module pulse_width_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rising_edge_i,
  input  logic             falling_edge_i,
  output logic [CNT_W-1:0] width_o,
  output logic             sat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             drop_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             sat_q, sat_nxt;
  logic             capture;
  logic             accept;
  logic             rise, fall;

  logic [CNT_W-1:0] width_q;
  logic             sat_out_q;
  logic             valid_q;
  logic             drop_q;

  // Coincident edges are a protocol violation and cancel each other out.
  assign rise = rising_edge_i & ~falling_edge_i;
  assign fall = falling_edge_i & ~rising_edge_i;

  assign accept = ~valid_q | ready_i;

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    sat_nxt   = sat_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          count_nxt = CNT_W'(1);
          sat_nxt   = (CNT_MAX == CNT_W'(1));
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (fall) begin
          capture   = 1'b1;
          count_nxt = '0;
          sat_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          count_nxt = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
          sat_nxt   = sat_q | (count_nxt == CNT_MAX);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sat_q     <= 1'b0;
      width_q   <= '0;
      sat_out_q <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      sat_q   <= sat_nxt;
      drop_q  <= capture & ~accept;
      // Same-cycle consume and capture hand the slot straight over with no bubble.
      if (capture && accept) begin
        width_q   <= count_q;
        sat_out_q <= sat_q;
        valid_q   <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign width_o = width_q;
  assign sat_o   = sat_out_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == MEASURE);
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Randomized and directed bench for pulse_width_meter at 16-bit and 4-bit counter widths.
module tb_pulse_width_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rising_edge = 1'b0;
  logic        falling_edge = 1'b0;
  logic        ready = 1'b0;

  logic [15:0] width16;
  logic        sat16, valid16, busy16, drop16;
  logic [3:0]  width4;
  logic        sat4, valid4, busy4, drop4;

  pulse_width_meter #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .rising_edge_i(rising_edge), .falling_edge_i(falling_edge),
    .width_o(width16), .sat_o(sat16), .valid_o(valid16),
    .ready_i(ready), .busy_o(busy16), .drop_o(drop16)
  );

  pulse_width_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rising_edge_i(rising_edge), .falling_edge_i(falling_edge),
    .width_o(width4), .sat_o(sat4), .valid_o(valid4),
    .ready_i(ready), .busy_o(busy4), .drop_o(drop4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checks_on = 1'b0;

  // Reference: pulse timing by timestamps, output slot as a one-entry mailbox.
  bit          m_in_pulse = 1'b0;
  int          m_start = 0;
  bit          m_valid = 1'b0;
  bit          m_drop = 1'b0;
  int          m_w16 = 0, m_w4 = 0;
  bit          m_sat16 = 1'b0, m_sat4 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("valid16", 32'(valid16), 32'(m_valid));
    check("valid4",  32'(valid4),  32'(m_valid));
    check("width16", 32'(width16), 32'(m_w16));
    check("width4",  32'(width4),  32'(m_w4));
    check("sat16",   32'(sat16),   32'(m_sat16));
    check("sat4",    32'(sat4),    32'(m_sat4));
    check("busy16",  32'(busy16),  32'(m_in_pulse));
    check("busy4",   32'(busy4),   32'(m_in_pulse));
    check("drop16",  32'(drop16),  32'(m_drop));
    check("drop4",   32'(drop4),   32'(m_drop));
  endtask

  task automatic model(input bit r, input bit f, input bit rdy, input bit rs);
    bit cap;
    int n;
    bit acc;
    cap = 1'b0;
    n = 0;
    if (rs) begin
      m_in_pulse = 1'b0;
      m_valid = 1'b0;
      m_drop = 1'b0;
      m_w16 = 0; m_w4 = 0;
      m_sat16 = 1'b0; m_sat4 = 1'b0;
      return;
    end
    if (!(r && f)) begin
      if (!m_in_pulse && r) begin
        m_in_pulse = 1'b1;
        m_start = cyc;
      end else if (m_in_pulse && f) begin
        cap = 1'b1;
        n = cyc - m_start;
        m_in_pulse = 1'b0;
      end
    end
    acc = !m_valid || rdy;
    m_drop = cap && !acc;
    if (cap && acc) begin
      m_valid = 1'b1;
      m_w16 = (n >= 65535) ? 65535 : n;
      m_sat16 = (n >= 65535);
      m_w4 = (n >= 15) ? 15 : n;
      m_sat4 = (n >= 15);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit f, input bit rdy, input bit rs);
    @(negedge clk);
    if (checks_on) compare_all();
    rising_edge = r;
    falling_edge = f;
    ready = rdy;
    rst = rs;
    model(r, f, rdy, rs);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Rising in one cycle, falling N cycles later.
  task automatic pulse(input int n, input bit rdy);
    step(1'b1, 1'b0, rdy, 1'b0);
    idle(n - 1, rdy);
    step(1'b0, 1'b1, rdy, 1'b0);
  endtask

  initial begin
    bit sig, sig_prev, r, f, rdy, rs;
    int run;

    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks_on = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    pulse(5, 1'b1);
    idle(3, 1'b1);

    pulse(1, 1'b1);
    pulse(3, 1'b1);
    idle(3, 1'b1);

    pulse(20, 1'b1);
    idle(3, 1'b1);

    pulse(4, 1'b0);
    idle(2, 1'b0);
    pulse(7, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    pulse(4, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    sig = 1'b0;
    sig_prev = 1'b0;
    run = 3;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        sig = ~sig;
        run = $urandom_range(1, 24);
      end
      run--;
      r = sig && !sig_prev;
      f = !sig && sig_prev;
      sig_prev = sig;
      if ($urandom_range(0, 31) == 0) begin
        r = 1'b1;
        f = 1'b1;
      end else if ($urandom_range(0, 47) == 0) begin
        r = $urandom_range(0, 1) != 0;
        f = !r;
      end
      rdy = $urandom_range(0, 3) != 0;
      rs = $urandom_range(0, 399) == 0;
      step(r, f, rdy, rs);
    end

    @(negedge clk);
    compare_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
